// File: rtl/psum_quant_pack_pkg.sv
// Shared widths and quantization constants for the post-accumulation stage.
// Latency: n/a (constants only).
// Backpressure: n/a.
package psum_quant_pack_pkg;

    // Adder-tree output width; the requant input is defined as this width.
    localparam int W_PSUM      = 32;
    localparam int W_ACC       = W_PSUM;
    localparam int W_BIAS      = 16;
    localparam int W_SCALE     = 16;
    localparam int W_SHIFT     = 5;
    localparam int W_Q         = 8;
    localparam int PACK        = 4;
    localparam int DEPTH       = 4;

    // int8 clamp range applied after requantization.
    localparam int Q_MIN       = -128;
    localparam int Q_MAX       = 127;

    // Leaky-ReLU slope is 1/2^LEAKY_SHIFT (used only in the leaky build).
    localparam int LEAKY_SHIFT = 3;

endpackage

// File: rtl/psum_quant_pack_sync_fifo.sv
// Generic show-ahead FIFO with occupancy count; head is visible on o_rd_dat.
// Latency: a write at edge M is visible at the head after edge M if it was empty.
// Backpressure: writes while full are ignored unless a read happens the same cycle.
module sync_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     i_wr_vld,
    input  logic [W-1:0]             i_wr_dat,
    input  logic                     i_rd_rdy,
    output logic [W-1:0]             o_rd_dat,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    logic w_full;
    logic w_rd_en;
    logic w_wr_en;

    assign w_full   = (r_count == (AW+1)'(DEPTH));
    assign w_rd_en  = i_rd_rdy && (r_count != '0);
    // A read frees the head slot this edge, so a write while full is still safe.
    assign w_wr_en  = i_wr_vld && (!w_full || w_rd_en);
    assign o_rd_dat = r_mem[r_rd_ptr];
    assign o_count  = r_count;

    // Storage write; contents need no reset because the count qualifies them.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= i_wr_dat;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/psum_quant_pack.sv
// Bias add, requantize (mul, round-half-up shift, activation, int8 clamp), pack 4 bytes, queue.
// Latency: input at edge N -> byte after N+3 -> word pushed at N+4; one input per cycle.
// Backpressure: none on input (upstream watches afull_o); full FIFO drops the word and sets ovf_o.
// Build option: define PSUM_QUANT_LEAKY_EN for leaky activation (r>>>3) instead of ReLU.
module psum_quant_pack #(
    parameter int W_ACC   = psum_quant_pack_pkg::W_ACC,
    parameter int W_BIAS  = psum_quant_pack_pkg::W_BIAS,
    parameter int W_SCALE = psum_quant_pack_pkg::W_SCALE,
    parameter int W_SHIFT = psum_quant_pack_pkg::W_SHIFT,
    parameter int W_Q     = psum_quant_pack_pkg::W_Q,
    parameter int PACK    = psum_quant_pack_pkg::PACK,
    parameter int DEPTH   = psum_quant_pack_pkg::DEPTH
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       vld_i,
    input  logic signed [W_ACC-1:0]    acc_i,
    input  logic signed [W_BIAS-1:0]   bias_i,
    input  logic signed [W_SCALE-1:0]  scale_i,
    input  logic [W_SHIFT-1:0]         shift_i,
    input  logic                       act_i,
    input  logic                       last_i,
    output logic [PACK*W_Q-1:0]        out_data_o,
    output logic                       out_vld_o,
    input  logic                       out_rdy_i,
    output logic                       afull_o,
    output logic                       ovf_o,
    input  logic                       clr_i
);
    import psum_quant_pack_pkg::*;

    localparam int W_B    = W_ACC + 1;
    localparam int W_P    = W_B + W_SCALE;
    localparam int W_LANE = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int W_CNT  = $clog2(DEPTH) + 1;

    localparam logic signed [W_P-1:0] P_QMAX = W_P'(Q_MAX);
    localparam logic signed [W_P-1:0] P_QMIN = W_P'(Q_MIN);

    // Stage 0: registered inputs
    logic                       r0_vld;
    logic signed [W_ACC-1:0]    r0_acc;
    logic signed [W_BIAS-1:0]   r0_bias;
    logic signed [W_SCALE-1:0]  r0_scale;
    logic [W_SHIFT-1:0]         r0_shift;
    logic                       r0_act;
    logic                       r0_last;
    // Stage 1: biased sum
    logic                       r1_vld;
    logic signed [W_B-1:0]      r1_b;
    logic signed [W_SCALE-1:0]  r1_scale;
    logic [W_SHIFT-1:0]         r1_shift;
    logic                       r1_act;
    logic                       r1_last;
    // Stage 2: scaled product
    logic                       r2_vld;
    logic signed [W_P-1:0]      r2_p;
    logic [W_SHIFT-1:0]         r2_shift;
    logic                       r2_act;
    logic                       r2_last;
    // Stage 3: quantized byte
    logic                       r3_vld;
    logic [W_Q-1:0]             r3_q;
    logic                       r3_last;

    logic signed [W_P-1:0]      w_rnd;
    logic signed [W_P-1:0]      w_sum;
    logic signed [W_P-1:0]      w_r;
    logic signed [W_P-1:0]      w_act;
    logic [W_Q-1:0]             w_q;

    // Packer and queue
    logic [W_LANE-1:0]          r_lane;
    logic [PACK*W_Q-1:0]        r_word;
    logic [PACK*W_Q-1:0]        w_word;
    logic                       w_push;
    logic [PACK*W_Q-1:0]        w_head;
    logic [W_CNT-1:0]           w_count;
    logic [W_CNT-1:0]           w_cnt_nxt;
    logic                       w_full;
    logic                       w_pop;
    logic                       w_push_ok;
    logic                       w_drop;
    logic                       r_afull;
    logic                       r_ovf;

    // Valid pipeline; only the valids carry reset so in-flight results vanish on reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r0_vld <= 1'b0;
            r1_vld <= 1'b0;
            r2_vld <= 1'b0;
            r3_vld <= 1'b0;
        end else begin
            r0_vld <= vld_i;
            r1_vld <= r0_vld;
            r2_vld <= r1_vld;
            r3_vld <= r2_vld;
        end
    end

    // Datapath registers: capture, bias add (one guard bit, no clamp), multiply, quantized byte.
    always_ff @(posedge clk) begin
        r0_acc   <= acc_i;
        r0_bias  <= bias_i;
        r0_scale <= scale_i;
        r0_shift <= shift_i;
        r0_act   <= act_i;
        r0_last  <= last_i;

        r1_b     <= W_B'(r0_acc) + W_B'(r0_bias);
        r1_scale <= r0_scale;
        r1_shift <= r0_shift;
        r1_act   <= r0_act;
        r1_last  <= r0_last;

        r2_p     <= W_P'(r1_b) * W_P'(r1_scale);
        r2_shift <= r1_shift;
        r2_act   <= r1_act;
        r2_last  <= r1_last;

        r3_q     <= w_q;
        r3_last  <= r2_last;
    end

    // Rounding shift (half-up), activation on negatives, then int8 clamp.
    always_comb begin
        w_rnd = '0;
        if (r2_shift != '0) begin
            w_rnd = W_P'(1) << (r2_shift - 1'b1);
        end
        w_sum = r2_p + w_rnd;
        w_r   = w_sum >>> r2_shift;
        w_act = w_r;
`ifdef PSUM_QUANT_LEAKY_EN
        if (r2_act && w_r[W_P-1]) begin
            w_act = w_r >>> LEAKY_SHIFT;
        end
`else
        if (r2_act && w_r[W_P-1]) begin
            w_act = '0;
        end
`endif
        if (w_act > P_QMAX) begin
            w_q = P_QMAX[W_Q-1:0];
        end else if (w_act < P_QMIN) begin
            w_q = P_QMIN[W_Q-1:0];
        end else begin
            w_q = w_act[W_Q-1:0];
        end
    end

    // Merge the new byte into the partial word; push on the last lane or an explicit last.
    always_comb begin
        w_word = r_word;
        w_word[r_lane*W_Q +: W_Q] = r3_q;
        w_push = r3_vld && ((r_lane == W_LANE'(PACK-1)) || r3_last);
    end

    // Lane counter; the partial word is cleared on push so upper lanes pad with zero.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_lane <= '0;
            r_word <= '0;
        end else if (r3_vld) begin
            if (w_push) begin
                r_lane <= '0;
                r_word <= '0;
            end else begin
                r_lane <= r_lane + 1'b1;
                r_word <= w_word;
            end
        end
    end

    sync_fifo #(
        .W     (PACK*W_Q),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rstn     (rstn),
        .i_wr_vld (w_push),
        .i_wr_dat (w_word),
        .i_rd_rdy (out_rdy_i),
        .o_rd_dat (w_head),
        .o_count  (w_count)
    );

    assign out_vld_o = (w_count != '0);
    assign w_full    = (w_count == W_CNT'(DEPTH));
    assign w_pop     = out_vld_o && out_rdy_i;
    assign w_push_ok = w_push && (!w_full || w_pop);
    assign w_drop    = w_push && w_full && !w_pop;
    assign w_cnt_nxt = w_count + W_CNT'(w_push_ok) - W_CNT'(w_pop);

    // Almost-full is registered from the next count so it tracks the count with no input path.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_afull <= 1'b0;
        end else begin
            r_afull <= (w_cnt_nxt >= W_CNT'(DEPTH-1));
        end
    end

    // Sticky overflow; a drop in the same cycle as clear keeps the flag set.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (clr_i) begin
            r_ovf <= 1'b0;
        end
    end

    assign afull_o    = r_afull;
    assign ovf_o      = r_ovf;
    assign out_data_o = out_vld_o ? w_head : '0;

endmodule

// File: tb/tb_psum_quant_pack.sv
module tb_psum_quant_pack;

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic               vld_i = 1'b0;
    logic signed [31:0] acc_i = '0;
    logic signed [15:0] bias_i = '0;
    logic signed [15:0] scale_i = '0;
    logic [4:0]         shift_i = '0;
    logic               act_i = 1'b0;
    logic               last_i = 1'b0;
    logic [31:0]        out_data_o;
    logic               out_vld_o;
    logic               out_rdy_i = 1'b1;
    logic               afull_o;
    logic               ovf_o;
    logic               clr_i = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] got[$];

    // Reference state: queued words, words scheduled for push, bytes of the open word.
    logic [31:0] mq[$];
    int          pdue[$];
    logic [31:0] pword[$];
    logic [7:0]  cb[$];
    logic        m_ovf = 1'b0;
    int          cyc = 0;

    always #5 clk = ~clk;

    psum_quant_pack dut (
        .clk        (clk),
        .rstn       (rstn),
        .vld_i      (vld_i),
        .acc_i      (acc_i),
        .bias_i     (bias_i),
        .scale_i    (scale_i),
        .shift_i    (shift_i),
        .act_i      (act_i),
        .last_i     (last_i),
        .out_data_o (out_data_o),
        .out_vld_o  (out_vld_o),
        .out_rdy_i  (out_rdy_i),
        .afull_o    (afull_o),
        .ovf_o      (ovf_o),
        .clr_i      (clr_i)
    );

    // Requantize one result with plain 64-bit arithmetic.
    function automatic logic [7:0] ref_q(input logic signed [31:0] a, input logic signed [15:0] bs,
                                         input logic signed [15:0] sc, input int sh, input logic ac);
        longint b, p, r;
        b = longint'(a) + longint'(bs);
        p = b * longint'(sc);
        if (sh > 0) r = (p + (longint'(1) <<< (sh - 1))) >>> sh;
        else        r = p;
        if (ac && r < 0) begin
`ifdef PSUM_QUANT_LEAKY_EN
            r = r >>> 3;
`else
            r = 0;
`endif
        end
        if (r > 127)  r = 127;
        if (r < -128) r = -128;
        return 8'(r);
    endfunction

    // Reference model advanced on every rising edge: word appears 4 edges after its closing input.
    initial begin : model
        logic        pop, push, drop;
        logic [31:0] w;
        forever begin
            @(posedge clk);
            if (!rstn) begin
                mq.delete(); pdue.delete(); pword.delete(); cb.delete();
                m_ovf = 1'b0;
            end else begin
                pop  = (mq.size() > 0) && out_rdy_i;
                push = (pdue.size() > 0) && (pdue[0] == cyc);
                drop = 1'b0;
                if (pop) void'(mq.pop_front());
                if (push) begin
                    w = pword[0];
                    void'(pdue.pop_front());
                    void'(pword.pop_front());
                    if (mq.size() == 4) begin
                        drop  = 1'b1;
                        m_ovf = 1'b1;
                    end else begin
                        mq.push_back(w);
                    end
                end
                if (clr_i && !drop) m_ovf = 1'b0;
                if (vld_i) begin
                    cb.push_back(ref_q(acc_i, bias_i, scale_i, int'(shift_i), act_i));
                    if (cb.size() == 4 || last_i) begin
                        w = '0;
                        foreach (cb[i]) w[8*i +: 8] = cb[i];
                        pdue.push_back(cyc + 4);
                        pword.push_back(w);
                        cb.delete();
                    end
                end
            end
            cyc++;
        end
    end

    // One input per call; called at a falling edge, returns at the next falling edge.
    task automatic drive(input int a, input int b, input int s, input int sh, input bit ac, input bit la);
        vld_i = 1'b1; acc_i = a; bias_i = 16'(b); scale_i = 16'(s);
        shift_i = 5'(sh); act_i = ac; last_i = la;
        @(negedge clk);
    endtask

    task automatic idle();
        vld_i = 1'b0; last_i = 1'b0; act_i = 1'b0;
    endtask

    // Record every word accepted by the consumer over a fixed window.
    task automatic collect(input int ncyc);
        got.delete();
        for (int i = 0; i < ncyc; i++) begin
            if (out_vld_o && out_rdy_i) got.push_back(out_data_o);
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; out_rdy_i = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++; if (out_vld_o !== 1'b0) begin n_err++; $display("FAIL reset_vld: got %b want 0", out_vld_o); end
        n_vec++; if (afull_o !== 1'b0) begin n_err++; $display("FAIL reset_afull: got %b want 0", afull_o); end
        n_vec++; if (ovf_o !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", ovf_o); end
        n_vec++; if (out_data_o !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h want 0", out_data_o); end
        rstn = 1'b1;
    endtask

    task automatic test_basic();
        drive(100, 0, 3, 2, 0, 0);
        drive(-100, 0, 3, 2, 0, 0);
        drive(4, 0, 1, 0, 0, 0);
        drive(-1, 0, 1, 0, 0, 1);
        idle();
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            n_vec++; if (out_vld_o !== 1'b0) begin n_err++; $display("FAIL basic_early_vld (cycle %0d): got %b want 0", k, out_vld_o); end
        end
        @(negedge clk);
        n_vec++; if (out_vld_o !== 1'b1) begin n_err++; $display("FAIL basic_latency_vld: got %b want 1", out_vld_o); end
        n_vec++; if (out_data_o !== 32'hFF04B54B) begin n_err++; $display("FAIL basic_word: got %h want ff04b54b", out_data_o); end
        @(negedge clk);
        n_vec++; if (out_vld_o !== 1'b0) begin n_err++; $display("FAIL basic_popped: got %b want 0", out_vld_o); end
    endtask

    task automatic test_saturate();
        logic [31:0] w;
        drive(1000, 24, 1, 3, 0, 0);
        drive(-5000, 0, 1, 0, 0, 1);
        idle();
        collect(10);
        n_vec++; if (got.size() != 1) begin n_err++; $display("FAIL sat_count: got %0d want 1", got.size()); end
        w = (got.size() > 0) ? got[0] : 'x;
        n_vec++; if (w !== 32'h0000807F) begin n_err++; $display("FAIL sat_word: got %h want 0000807f", w); end
    endtask

    task automatic test_activation();
        logic [31:0] w, e;
`ifdef PSUM_QUANT_LEAKY_EN
        e = 32'h0000F64B;
`else
        e = 32'h0000004B;
`endif
        drive(100, 0, 3, 2, 1, 0);
        drive(-100, 0, 3, 2, 1, 1);
        idle();
        collect(10);
        w = (got.size() > 0) ? got[0] : 'x;
        n_vec++; if (w !== e) begin n_err++; $display("FAIL act_word: got %h want %h", w, e); end
    endtask

    task automatic test_packing();
        logic [31:0] exp_w [3] = '{32'h04030201, 32'h00000605, 32'h00000007};
        logic [31:0] w;
        for (int k = 1; k <= 5; k++) drive(k, 0, 1, 0, 0, 0);
        drive(6, 0, 1, 0, 0, 1);
        drive(7, 0, 1, 0, 0, 1);
        idle();
        collect(12);
        n_vec++; if (got.size() != 3) begin n_err++; $display("FAIL pack_count: got %0d want 3", got.size()); end
        for (int k = 0; k < 3; k++) begin
            w = (got.size() > k) ? got[k] : 'x;
            n_vec++; if (w !== exp_w[k]) begin n_err++; $display("FAIL pack_word%0d: got %h want %h", k, w, exp_w[k]); end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] exp_w [4] = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D};
        out_rdy_i = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            n_vec++; if (afull_o !== (mq.size() >= 3)) begin n_err++; $display("FAIL ovf_afull_track (input %0d): got %b want %b", i, afull_o, mq.size() >= 3); end
            drive(i, 0, 1, 0, 0, 0);
        end
        idle();
        repeat (6) @(negedge clk);
        n_vec++; if (afull_o !== 1'b1) begin n_err++; $display("FAIL ovf_afull: got %b want 1", afull_o); end
        n_vec++; if (ovf_o !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b want 1", ovf_o); end
        clr_i = 1'b1;
        @(negedge clk);
        clr_i = 1'b0;
        n_vec++; if (ovf_o !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b want 0", ovf_o); end
        out_rdy_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_vec++; if (out_vld_o !== 1'b1) begin n_err++; $display("FAIL drain_vld%0d: got %b want 1", k, out_vld_o); end
            n_vec++; if (out_data_o !== exp_w[k]) begin n_err++; $display("FAIL drain_word%0d: got %h want %h", k, out_data_o, exp_w[k]); end
            @(negedge clk);
        end
        n_vec++; if (out_vld_o !== 1'b0) begin n_err++; $display("FAIL drain_empty: got %b want 0", out_vld_o); end
    endtask

    task automatic test_full_pushpop();
        logic [31:0] exp_w [4] = '{32'h08070605, 32'h0C0B0A09, 32'h100F0E0D, 32'h14131211};
        logic [31:0] w;
        out_rdy_i = 1'b0;
        for (int i = 1; i <= 20; i++) drive(i, 0, 1, 0, 0, 0);
        idle();
        repeat (3) @(negedge clk);
        out_rdy_i = 1'b1;
        @(negedge clk);
        out_rdy_i = 1'b0;
        n_vec++; if (ovf_o !== 1'b0) begin n_err++; $display("FAIL full_pp_ovf: got %b want 0", ovf_o); end
        n_vec++; if (afull_o !== 1'b1) begin n_err++; $display("FAIL full_pp_afull: got %b want 1", afull_o); end
        out_rdy_i = 1'b1;
        collect(8);
        n_vec++; if (got.size() != 4) begin n_err++; $display("FAIL full_pp_count: got %0d want 4", got.size()); end
        for (int k = 0; k < 4; k++) begin
            w = (got.size() > k) ? got[k] : 'x;
            n_vec++; if (w !== exp_w[k]) begin n_err++; $display("FAIL full_pp_word%0d: got %h want %h", k, w, exp_w[k]); end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] w;
        out_rdy_i = 1'b0;
        for (int i = 1; i <= 11; i++) drive(i, 0, 1, 0, 0, 0);
        n_vec++; if (out_vld_o !== 1'b1) begin n_err++; $display("FAIL midrst_pre_vld: got %b want 1", out_vld_o); end
        rstn = 1'b0;
        drive(12, 0, 1, 0, 0, 0);
        idle();
        n_vec++; if (out_vld_o !== 1'b0) begin n_err++; $display("FAIL midrst_vld: got %b want 0", out_vld_o); end
        n_vec++; if (afull_o !== 1'b0) begin n_err++; $display("FAIL midrst_afull: got %b want 0", afull_o); end
        n_vec++; if (ovf_o !== 1'b0) begin n_err++; $display("FAIL midrst_ovf: got %b want 0", ovf_o); end
        n_vec++; if (out_data_o !== 32'h0) begin n_err++; $display("FAIL midrst_data: got %h want 0", out_data_o); end
        rstn = 1'b1;
        out_rdy_i = 1'b1;
        drive(85, 0, 1, 0, 0, 0);
        drive(102, 0, 1, 0, 0, 1);
        idle();
        collect(12);
        n_vec++; if (got.size() != 1) begin n_err++; $display("FAIL midrst_count: got %0d want 1", got.size()); end
        w = (got.size() > 0) ? got[0] : 'x;
        n_vec++; if (w !== 32'h00006655) begin n_err++; $display("FAIL midrst_word: got %h want 00006655", w); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            n_vec++; if (out_vld_o !== (mq.size() > 0)) begin n_err++; $display("FAIL rnd_vld (cycle %0d): got %b want %b", c, out_vld_o, mq.size() > 0); end
            if (mq.size() > 0) begin
                n_vec++; if (out_data_o !== mq[0]) begin n_err++; $display("FAIL rnd_data (cycle %0d): got %h want %h", c, out_data_o, mq[0]); end
            end
            n_vec++; if (afull_o !== (mq.size() >= 3)) begin n_err++; $display("FAIL rnd_afull (cycle %0d): got %b want %b", c, afull_o, mq.size() >= 3); end
            n_vec++; if (ovf_o !== m_ovf) begin n_err++; $display("FAIL rnd_ovf (cycle %0d): got %b want %b", c, ovf_o, m_ovf); end
            rstn    = ($urandom_range(0, 249) != 0);
            vld_i   = ($urandom_range(0, 3) != 0);
            acc_i   = ($urandom_range(0, 1) != 0) ? int'($urandom) : int'($urandom_range(0, 6000)) - 3000;
            bias_i  = 16'($urandom);
            scale_i = ($urandom_range(0, 1) != 0) ? 16'($urandom) : 16'(int'($urandom_range(0, 16)) - 8);
            shift_i = ($urandom_range(0, 1) != 0) ? 5'($urandom) : 5'($urandom_range(0, 6));
            act_i   = 1'($urandom);
            last_i  = ($urandom_range(0, 4) == 0);
            out_rdy_i = ((c % 80) < 25) ? 1'b0 : ($urandom_range(0, 2) != 0);
            clr_i   = ($urandom_range(0, 15) == 0);
            @(negedge clk);
        end
        rstn = 1'b1; clr_i = 1'b0; out_rdy_i = 1'b1;
        idle();
        repeat (8) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturate();
        test_activation();
        test_packing();
        test_overflow();
        test_full_pushpop();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
